// File: rtl/fetch_unit.sv
// Instruction-fetch control stage. Holds the PC, drives it to a combinational
// instruction memory, and registers the returned word with its PC into a
// single-entry output stage that decode drains over a valid/ready handshake.
// Execute can redirect the PC at any time; a redirect squashes the presented
// entry and suppresses the fetch in that cycle.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_INC   = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            FETCH_EN,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic [XLEN-1:0] IMEM_RDATA,
  input  logic            REDIRECT_VALID,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic [XLEN-1:0] INSTR_OUT,
  output logic [XLEN-1:0] PC_OUT,
  output logic            VALID_OUT,
  input  logic            READY_IN
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic            valid_q, valid_d;

  logic            load;
  logic            xfer;
  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] pc_next_seq;

  // Redirect targets are word aligned; the low two bits carry no meaning.
  logic [1:0]      unused_redirect_lsbs;
  assign unused_redirect_lsbs = REDIRECT_PC[1:0];

  // The memory is addressed straight from the PC in every state.
  assign IMEM_ADDR = pc_q;

  assign INSTR_OUT = instr_q;
  assign PC_OUT    = pc_out_q;
  assign VALID_OUT = valid_q;

  // A fetch happens only while running, not on a redirect cycle, and only
  // when the output slot is empty or being drained this same edge.
  always_comb begin
    xfer         = valid_q && READY_IN;
    load         = (state_q == RUN) && FETCH_EN && !REDIRECT_VALID &&
                   (!valid_q || READY_IN);
    redirect_tgt = {REDIRECT_PC[XLEN-1:2], 2'b00};
    // Plain modular add: the top word address wraps back to zero.
    pc_next_seq  = pc_q + XLEN'(PC_INC);
  end

  // Next-state selection: redirect beats load beats transfer beats hold.
  always_comb begin
    state_d  = FETCH_EN ? RUN : IDLE;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;

    if (REDIRECT_VALID) begin
      // Squash whatever is presented, transferred or not; no fetch this cycle.
      pc_d    = redirect_tgt;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d  = IMEM_RDATA;
      pc_out_d = pc_q;
      valid_d  = 1'b1;
      pc_d     = pc_next_seq;
    end else if (xfer) begin
      // Consumer took the entry and nothing refills it; data fields hold.
      valid_d = 1'b0;
    end
  end

  // State register, including the IDLE/RUN FSM; reset clears everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, backpressure, redirect,
// fetch-enable drop, PC wrap, mid-run reset and a squash under backpressure.
module tb_fetch_unit;

  logic        CLK;
  logic        RST;
  logic        FETCH_EN;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA;
  logic        REDIRECT_VALID;
  logic [31:0] REDIRECT_PC;
  logic [31:0] INSTR_OUT;
  logic [31:0] PC_OUT;
  logic        VALID_OUT;
  logic        READY_IN;

  int checks;
  int errors;

  fetch_unit #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000),
    .PC_INC  (4)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .FETCH_EN      (FETCH_EN),
    .IMEM_ADDR     (IMEM_ADDR),
    .IMEM_RDATA    (IMEM_RDATA),
    .REDIRECT_VALID(REDIRECT_VALID),
    .REDIRECT_PC   (REDIRECT_PC),
    .INSTR_OUT     (INSTR_OUT),
    .PC_OUT        (PC_OUT),
    .VALID_OUT     (VALID_OUT),
    .READY_IN      (READY_IN)
  );

  // Combinational memory: word content tags its own address.
  assign IMEM_RDATA = 32'hA000_0000 | IMEM_ADDR;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [31:0] pc,
                         input logic [31:0] instr, input logic [31:0] addr);
    chk({tag, ".valid"}, {31'd0, VALID_OUT}, {31'd0, vld});
    chk({tag, ".pc_out"}, PC_OUT, pc);
    chk({tag, ".instr"}, INSTR_OUT, instr);
    chk({tag, ".imem_addr"}, IMEM_ADDR, addr);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    RST            = 1'b1;
    FETCH_EN       = 1'b0;
    READY_IN       = 1'b1;
    REDIRECT_VALID = 1'b0;
    REDIRECT_PC    = 32'h0;

    // 1. Reset then stream
    tick();
    tick();
    chk_out("reset", 1'b0, 32'h0, 32'h0, 32'h0);
    RST      = 1'b0;
    FETCH_EN = 1'b1;
    tick();
    chk_out("idle_to_run", 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    chk_out("first_load", 1'b1, 32'h0, 32'hA000_0000, 32'h4);
    tick();
    chk_out("stream_4", 1'b1, 32'h4, 32'hA000_0004, 32'h8);
    tick();
    chk_out("stream_8", 1'b1, 32'h8, 32'hA000_0008, 32'hC);

    // 2. Backpressure with PC_OUT=8 presented
    READY_IN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("stall", 1'b1, 32'h8, 32'hA000_0008, 32'hC);
    end
    READY_IN = 1'b1;
    tick();
    chk_out("stall_release", 1'b1, 32'hC, 32'hA000_000C, 32'h10);
    tick();
    chk_out("stream_16", 1'b1, 32'h10, 32'hA000_0010, 32'h14);

    // 3. Redirect while an entry is being transferred
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'h0000_0043;
    tick();
    chk_out("redirect", 1'b0, 32'h10, 32'hA000_0010, 32'h40);
    REDIRECT_VALID = 1'b0;
    tick();
    chk_out("redirect_load", 1'b1, 32'h40, 32'hA000_0040, 32'h44);

    // 4. FETCH_EN drop with entry held under backpressure
    READY_IN = 1'b0;
    FETCH_EN = 1'b0;
    tick();
    chk_out("fen_drop", 1'b1, 32'h40, 32'hA000_0040, 32'h44);
    tick();
    chk_out("fen_drop_hold", 1'b1, 32'h40, 32'hA000_0040, 32'h44);
    READY_IN = 1'b1;
    tick();
    chk_out("idle_drain", 1'b0, 32'h40, 32'hA000_0040, 32'h44);
    tick();
    chk_out("idle_frozen", 1'b0, 32'h40, 32'hA000_0040, 32'h44);
    FETCH_EN = 1'b1;
    tick();
    chk_out("restart_run", 1'b0, 32'h40, 32'hA000_0040, 32'h44);
    tick();
    chk_out("restart_load", 1'b1, 32'h44, 32'hA000_0044, 32'h48);

    // 5. Wrap at the top of the address space, then mid-run reset
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'hFFFF_FFFC;
    tick();
    chk_out("redirect_top", 1'b0, 32'h44, 32'hA000_0044, 32'hFFFF_FFFC);
    REDIRECT_VALID = 1'b0;
    tick();
    chk_out("wrap_top", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0);
    tick();
    chk_out("wrap_zero", 1'b1, 32'h0, 32'hA000_0000, 32'h4);
    RST = 1'b1;
    tick();
    chk_out("mid_reset", 1'b0, 32'h0, 32'h0, 32'h0);

    // 6. Squash of a stalled entry by redirect
    RST = 1'b0;
    tick();
    chk_out("rerun", 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    chk_out("reload", 1'b1, 32'h0, 32'hA000_0000, 32'h4);
    READY_IN       = 1'b0;
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'h0000_0102;
    tick();
    chk_out("squash_stalled", 1'b0, 32'h0, 32'hA000_0000, 32'h100);
    REDIRECT_VALID = 1'b0;
    tick();
    chk_out("post_squash", 1'b1, 32'h100, 32'hA000_0100, 32'h104);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch control stage of the RISC-V lite core. It sits directly upstream of the instruction memory, which is combinational: the memory returns read data in the same cycle it receives an address.
- Holds the program counter and drives it to the memory as the read address.
- Registers the returned word together with its PC into a single-entry output stage.
- Hands that entry to decode over a valid/ready handshake.
- Accepts control-flow redirects from execute.

Parameters:
XLEN, 32, data and address width in bits.
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_INC, 4, byte increment applied to the PC after each fetch.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RST  in  1  synchronous, active-high reset.
FETCH_EN  in  1  1 = fetching permitted; 0 = stop issuing new fetches.
IMEM_ADDR  out  XLEN  instruction memory byte address; always equals the PC.
IMEM_RDATA  in  XLEN  instruction word at IMEM_ADDR, valid in the same cycle.
REDIRECT_VALID  in  1  one-cycle pulse from execute: redirect the PC.
REDIRECT_PC  in  XLEN  redirect target; bits [1:0] are ignored.
INSTR_OUT  out  XLEN  registered instruction presented to decode.
PC_OUT  out  XLEN  PC of INSTR_OUT.
VALID_OUT  out  1  INSTR_OUT / PC_OUT hold a valid instruction.
READY_IN  in  1  decode can accept this cycle.

Behaviour:
- Registers: PC, INSTR_OUT, PC_OUT, VALID_OUT, and a 1-bit FSM state {IDLE, RUN}.
- IMEM_ADDR = PC, combinational, in every state.
- Reset (RST=1 at an edge) overrides everything, including mid-operation:
  - PC=RESET_PC, INSTR_OUT=0, PC_OUT=0, VALID_OUT=0, state=IDLE.
- FSM:
  - IDLE -> RUN at an edge where FETCH_EN=1. No fetch is performed in the transition cycle.
  - RUN -> IDLE at an edge where FETCH_EN=0. A held VALID_OUT entry stays presented until it is consumed.
- Transfer: VALID_OUT && READY_IN at an edge. A transfer always counts as completed by the consumer, including in a redirect cycle.
- load = (state==RUN) && FETCH_EN && !REDIRECT_VALID && (!VALID_OUT || READY_IN).
- On load:
  - INSTR_OUT <= IMEM_RDATA, PC_OUT <= PC, VALID_OUT <= 1.
  - PC <= PC + PC_INC, modulo 2^XLEN; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Transfer without load: VALID_OUT <= 0; INSTR_OUT and PC_OUT hold their values.
- Stall (VALID_OUT=1, READY_IN=0): PC, INSTR_OUT, PC_OUT and VALID_OUT are all stable until READY_IN rises.
- Redirect (REDIRECT_VALID=1, any state, RST=0):
  - PC <= {REDIRECT_PC[XLEN-1:2], 2'b00}.
  - VALID_OUT <= 0, which squashes the presented entry whether or not it transferred.
  - No load occurs in that cycle; INSTR_OUT and PC_OUT hold.
  - The state does not change because of the redirect. It still follows FETCH_EN as above.
- Latency: the word at PC appears on INSTR_OUT/VALID_OUT the cycle after its load edge.
- First valid output: VALID_OUT first rises after the second rising edge at which FETCH_EN is sampled 1 following reset. The first edge moves the FSM to RUN; the second performs the load.
- Throughput: with READY_IN=1 and no redirects, one instruction per cycle and PC increments by PC_INC every cycle.
- Only these registers: no prefetch buffer, no outstanding-request tracking. Memory is combinational.

Test Plan:
1. Reset then stream. RST 2 cycles, FETCH_EN=1, READY_IN=1; memory model returns 32'hA000_0000 | IMEM_ADDR.
   -> VALID_OUT=0 after reset; VALID_OUT rises after the 2nd edge with FETCH_EN=1.
   -> Then each cycle: PC_OUT 0,4,8,12 with INSTR_OUT A000_0000, A000_0004, A000_0008, A000_000C.
2. Backpressure. While streaming, READY_IN=0 for 3 cycles with PC_OUT=8 presented.
   -> INSTR_OUT=A000_0008, PC_OUT=8 held; IMEM_ADDR=12 held.
   -> On READY_IN=1, PC_OUT=12 appears next cycle; no entry skipped or duplicated.
3. Redirect. Pulse REDIRECT_VALID with REDIRECT_PC=32'h0000_0043 while VALID_OUT=1 and READY_IN=1.
   -> Next cycle: VALID_OUT=0, IMEM_ADDR=0x40.
   -> Following cycle: VALID_OUT=1, PC_OUT=0x40, INSTR_OUT=A000_0040.
4. FETCH_EN drop. Deassert FETCH_EN with an entry presented and READY_IN=0.
   -> Entry held; state goes to IDLE; no PC change.
   -> READY_IN=1 -> VALID_OUT=0; PC frozen until FETCH_EN=1 again, then +2 cycles to the next VALID_OUT.
5. Wrap and mid-run reset. Redirect to 32'hFFFF_FFFC, stream 2 instructions.
   -> PC_OUT FFFF_FFFC then 0000_0000.
   -> Assert RST mid-stream -> next cycle all outputs 0, IMEM_ADDR=RESET_PC.
